uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_if.sv | 10 +
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx.sv | 131 +++++++++++++
 tb/tb_uart_rx.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default line timing.
// UART_RX_PARITY_EN adds the PARITY state for the even-parity build.
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ = 50_000_000;
  localparam int unsigned DEF_BAUD     = 115200;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, received byte and status pulses out.
interface uart_rx_if;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;

  modport master (input uart_rx, output rx_data, output rx_valid, output frame_err);
  modport slave  (output uart_rx, input rx_data, input rx_valid, input frame_err);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level.
module uart_rx_sync (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling. Defining UART_RX_PARITY_EN adds an
// even-parity bit between bit 7 and the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned BAUD     = DEF_BAUD
) (
  input  logic     sys_clk,
  input  logic     rst_n,
  uart_rx_if.master bus
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);

  logic             w_rx_s;
  logic             r_rx_d;
  rx_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_frame_err;
  logic             w_stop_ok;

  uart_rx_sync u_sync (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .i_d     (bus.uart_rx),
    .o_q     (w_rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic r_par_err;
  assign w_stop_ok = w_rx_s & ~r_par_err;
`else
  assign w_stop_ok = w_rx_s;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_d      <= 1'b1;
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err   <= 1'b0;
`endif
    end else begin
      r_rx_d      <= w_rx_s;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_cnt <= '0;
          // Edge-triggered start keeps a held-low (break) line from retriggering.
          if (r_rx_d && !w_rx_s) begin
            r_state <= StStart;
            r_bit   <= '0;
          end
        end
        StStart: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt   <= '0;
            r_state <= w_rx_s ? StIdle : StData;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StData: begin
          if (r_cnt == CNT_FULL) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= StParity;
`else
              r_state <= StStop;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (r_cnt == CNT_FULL) begin
            r_cnt     <= '0;
            r_par_err <= w_rx_s != ^r_shift;
            r_state   <= StStop;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        StStop: begin
          if (r_cnt == CNT_FULL) begin
            r_cnt   <= '0;
            r_state <= StIdle;
            if (w_stop_ok) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default timing (434 clocks per bit).
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT = 434;

  logic sys_clk;
  logic rst_n;
  uart_rx_if u_if ();

  uart_rx dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (u_if)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic [7:0] data_log [16];

  always @(negedge sys_clk) begin
    if (u_if.rx_valid && u_if.frame_err) both_cnt = both_cnt + 1;
    if (u_if.rx_valid) begin
      data_log[valid_cnt % 16] = u_if.rx_data;
      valid_cnt = valid_cnt + 1;
    end
    if (u_if.frame_err) err_cnt = err_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_bit(input logic b);
    u_if.uart_rx = b;
    wait_clk(BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(1'b1);
  endtask
`endif

  task automatic test_reset();
    rst_n = 1'b0;
    u_if.uart_rx = 1'b1;
    wait_clk(5);
    n_checks++;
    if (u_if.rx_data !== 8'h00) begin
      n_errors++; $display("FAIL reset_rx_data got=%h exp=00", u_if.rx_data);
    end
    n_checks++;
    if (u_if.rx_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_rx_valid got=%b exp=0", u_if.rx_valid);
    end
    n_checks++;
    if (u_if.frame_err !== 1'b0) begin
      n_errors++; $display("FAIL reset_frame_err got=%b exp=0", u_if.frame_err);
    end
    rst_n = 1'b1;
    wait_clk(20);
  endtask

  task automatic test_single();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    send_frame(8'h55, 1'b1);
    wait_clk(BIT);
    n_checks++;
    if (valid_cnt - v0 !== 1) begin
      n_errors++; $display("FAIL single_valid_count got=%0d exp=1", valid_cnt - v0);
    end
    n_checks++;
    if (data_log[v0 % 16] !== 8'h55) begin
      n_errors++; $display("FAIL single_pulse_data got=%h exp=55", data_log[v0 % 16]);
    end
    n_checks++;
    if (u_if.rx_data !== 8'h55) begin
      n_errors++; $display("FAIL single_rx_data_hold got=%h exp=55", u_if.rx_data);
    end
    n_checks++;
    if (err_cnt - e0 !== 0) begin
      n_errors++; $display("FAIL single_frame_err got=%0d exp=0", err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_clk(BIT);
    n_checks++;
    if (valid_cnt - v0 !== 2) begin
      n_errors++; $display("FAIL b2b_valid_count got=%0d exp=2", valid_cnt - v0);
    end
    n_checks++;
    if (data_log[v0 % 16] !== 8'h00) begin
      n_errors++; $display("FAIL b2b_first_data got=%h exp=00", data_log[v0 % 16]);
    end
    n_checks++;
    if (data_log[(v0 + 1) % 16] !== 8'hFF) begin
      n_errors++; $display("FAIL b2b_second_data got=%h exp=ff", data_log[(v0 + 1) % 16]);
    end
    n_checks++;
    if (err_cnt - e0 !== 0) begin
      n_errors++; $display("FAIL b2b_frame_err got=%0d exp=0", err_cnt - e0);
    end
  endtask

  task automatic test_glitch();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    u_if.uart_rx = 1'b0;
    wait_clk(100);
    u_if.uart_rx = 1'b1;
    wait_clk(3 * BIT);
    n_checks++;
    if (valid_cnt - v0 !== 0) begin
      n_errors++; $display("FAIL glitch_valid got=%0d exp=0", valid_cnt - v0);
    end
    n_checks++;
    if (err_cnt - e0 !== 0) begin
      n_errors++; $display("FAIL glitch_frame_err got=%0d exp=0", err_cnt - e0);
    end
    n_checks++;
    if (dut.r_state !== StIdle) begin
      n_errors++; $display("FAIL glitch_state got=%0d exp=%0d", dut.r_state, StIdle);
    end
  endtask

  task automatic test_frame_err();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    send_frame(8'hA3, 1'b0);
    wait_clk(3 * BIT);
    n_checks++;
    if (err_cnt - e0 !== 1) begin
      n_errors++; $display("FAIL ferr_count got=%0d exp=1", err_cnt - e0);
    end
    n_checks++;
    if (valid_cnt - v0 !== 0) begin
      n_errors++; $display("FAIL ferr_valid got=%0d exp=0", valid_cnt - v0);
    end
    n_checks++;
    if (u_if.rx_data !== 8'hFF) begin
      n_errors++; $display("FAIL ferr_rx_data_kept got=%h exp=ff", u_if.rx_data);
    end
    u_if.uart_rx = 1'b1;
    wait_clk(3 * BIT);
    n_checks++;
    if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0) begin
      n_errors++;
      $display("FAIL ferr_no_retrigger got err=%0d valid=%0d exp err=1 valid=0",
               err_cnt - e0, valid_cnt - v0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d = 8'hC3;
    int v0 = valid_cnt;
    int e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    u_if.uart_rx = d[4];
    wait_clk(200);
    rst_n = 1'b0;
    wait_clk(3);
    n_checks++;
    if (u_if.rx_data !== 8'h00 || u_if.rx_valid !== 1'b0 || u_if.frame_err !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_outputs got data=%h v=%b fe=%b exp data=00 v=0 fe=0",
               u_if.rx_data, u_if.rx_valid, u_if.frame_err);
    end
    u_if.uart_rx = 1'b1;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(12 * BIT);
    n_checks++;
    if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin
      n_errors++;
      $display("FAIL midrst_no_pulse got valid=%0d err=%0d exp 0 0", valid_cnt - v0, err_cnt - e0);
    end
    send_frame(8'h3C, 1'b1);
    wait_clk(BIT);
    n_checks++;
    if (valid_cnt - v0 !== 1 || u_if.rx_data !== 8'h3C) begin
      n_errors++;
      $display("FAIL midrst_resume got valid=%0d data=%h exp valid=1 data=3c",
               valid_cnt - v0, u_if.rx_data);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    send_frame_par(8'h07, 1'b0);
    wait_clk(BIT);
    n_checks++;
    if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0) begin
      n_errors++;
      $display("FAIL parity_bad got err=%0d valid=%0d exp err=1 valid=0",
               err_cnt - e0, valid_cnt - v0);
    end
    send_frame_par(8'h07, 1'b1);
    wait_clk(BIT);
    n_checks++;
    if (valid_cnt - v0 !== 1 || u_if.rx_data !== 8'h07 || err_cnt - e0 !== 1) begin
      n_errors++;
      $display("FAIL parity_good got valid=%0d data=%h err=%0d exp valid=1 data=07 err=1",
               valid_cnt - v0, u_if.rx_data, err_cnt - e0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    n_checks++;
    if (both_cnt !== 0) begin
      n_errors++; $display("FAIL valid_and_ferr_together got=%0d exp=0", both_cnt);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
